// File: rtl/ptch_est.sv
// Pitch estimator: configures the IMU over SPI after power-up, then on each data-ready
// reads pitch rate and Z acceleration and fuses them into a pitch angle estimate.
module ptch_est #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] ptch,
  output logic        vld
);

  localparam int TW = FAST_SIM ? 10 : 16;

  typedef enum logic [3:0] {
    WAIT, INIT1, INIT2, INIT3, INIT4, IDLE, RD_RL, RD_RH, RD_AL, RD_AH, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          int_ff1_q, int_ff2_q;
  logic          wrt_q, wrt_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [7:0]    rl_q, rh_q, al_q, ah_q;
  logic          cap_rl, cap_rh, cap_al, cap_ah;
  logic          vld_q, vld_d;
  logic [15:0]   ptch_rt_q;
  logic [26:0]   ptch_int_q, ptch_int_d;

  logic [15:0]        az_comp;
  logic signed [25:0] az_ext, prod;
  logic [15:0]        ptch_acc;
  logic               acc_gt;
  logic [26:0]        fusion;
  logic               unused_prod_lo, unused_rd_hi;

  // Outputs are registered so spi_cmd stays put from the spi_wrt pulse until spi_done.
  always_comb begin
    state_d = state_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    cap_rl  = 1'b0;
    cap_rh  = 1'b0;
    cap_al  = 1'b0;
    cap_ah  = 1'b0;
    case (state_q)
      WAIT: if (&timer_q) begin
        wrt_d = 1'b1; cmd_d = 16'h0D02; state_d = INIT1;
      end
      INIT1: if (spi_done) begin
        wrt_d = 1'b1; cmd_d = 16'h1160; state_d = INIT2;
      end
      INIT2: if (spi_done) begin
        wrt_d = 1'b1; cmd_d = 16'h1050; state_d = INIT3;
      end
      INIT3: if (spi_done) begin
        wrt_d = 1'b1; cmd_d = 16'h1460; state_d = INIT4;
      end
      INIT4: if (spi_done) state_d = IDLE;
      IDLE: if (int_ff2_q) begin
        wrt_d = 1'b1; cmd_d = 16'hA200; state_d = RD_RL;
      end
      RD_RL: if (spi_done) begin
        cap_rl = 1'b1; wrt_d = 1'b1; cmd_d = 16'hA300; state_d = RD_RH;
      end
      RD_RH: if (spi_done) begin
        cap_rh = 1'b1; wrt_d = 1'b1; cmd_d = 16'hAC00; state_d = RD_AL;
      end
      RD_AL: if (spi_done) begin
        cap_al = 1'b1; wrt_d = 1'b1; cmd_d = 16'hAD00; state_d = RD_AH;
      end
      RD_AH: if (spi_done) begin
        cap_ah = 1'b1; state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = WAIT;
    endcase
  end

  assign vld_d = (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT;
      timer_q   <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      if (state_q == WAIT) timer_q <= timer_q + TW'(1);
    end
  end

  // RH/RL are already captured when the last byte arrives, so the rate is ready in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rl_q      <= 8'h00;
      rh_q      <= 8'h00;
      al_q      <= 8'h00;
      ah_q      <= 8'h00;
      ptch_rt_q <= 16'h0000;
    end else begin
      if (cap_rl) rl_q <= spi_rd[7:0];
      if (cap_rh) rh_q <= spi_rd[7:0];
      if (cap_al) al_q <= spi_rd[7:0];
      if (cap_ah) begin
        ah_q      <= spi_rd[7:0];
        ptch_rt_q <= {rh_q, rl_q} - 16'h0050;
      end
    end
  end

  // Accelerometer-derived pitch: (az - offset) * 327 / 8192, as a 13-bit signed value.
  assign az_comp        = {ah_q, al_q} - 16'h00A0;
  assign az_ext         = {{10{az_comp[15]}}, az_comp};
  assign prod           = az_ext * 26'sd327;
  assign ptch_acc       = {{3{prod[25]}}, prod[25:13]};
  assign unused_prod_lo = ^prod[12:0];
  assign unused_rd_hi   = ^spi_rd[15:8];

  // Complementary filter: integrate rate, nudge towards the accelerometer estimate.
  assign acc_gt     = $signed(ptch_acc) > $signed(ptch);
  assign fusion     = acc_gt ? 27'd1024 : 27'h7FF_FC00;
  assign ptch_int_d = ptch_int_q - {{11{ptch_rt_q[15]}}, ptch_rt_q} + fusion;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int_q <= 27'd0;
    end else if (vld_q) begin
      ptch_int_q <= ptch_int_d;
    end
  end

  assign spi_wrt = wrt_q;
  assign spi_cmd = cmd_q;
  assign ptch_rt = ptch_rt_q;
  assign ptch    = ptch_int_q[26:11];
  assign vld     = vld_q;

endmodule

// File: tb/tb_ptch_est.sv
// Directed bench for ptch_est: SPI slave answering 4 clks after each spi_wrt,
// init sequence, single and back-to-back reads, mid-read reset and fusion settling.
`timescale 1ns/1ps
module tb_ptch_est;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [15:0] ptch_rt;
  logic [15:0] ptch;
  logic        vld;

  always #5 clk = ~clk;

  ptch_est #(.FAST_SIM(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .spi_done (spi_done),
    .spi_rd   (spi_rd),
    .spi_wrt  (spi_wrt),
    .spi_cmd  (spi_cmd),
    .ptch_rt  (ptch_rt),
    .ptch     (ptch),
    .vld      (vld)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          vld_cyc = 0;
  int          vld_mon = 0;
  int          overlap_cnt = 0;
  int          pend = 0;
  logic [15:0] cmd_log[$];
  logic [7:0]  rsp_byte = 8'h00;
  logic [7:0]  rl_v = 8'h00, rh_v = 8'h00, al_v = 8'h00, ah_v = 8'h00;
  logic [26:0] m_int = 27'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_for(input logic [15:0] c);
    case (c)
      16'hA200: return rl_v;
      16'hA300: return rh_v;
      16'hAC00: return al_v;
      16'hAD00: return ah_v;
      default:  return 8'h00;
    endcase
  endfunction

  // SPI slave: spi_done is seen by the DUT on the 4th rising edge after spi_wrt.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            spi_done = 1'b1;
            spi_rd   = {8'hC3, rsp_byte};
          end
        end
        if (spi_wrt) begin
          if (pend > 0) overlap_cnt++;
          cmd_log.push_back(spi_cmd);
          $display("[%0d] spi_wrt cmd=0x%04h", cyc, spi_cmd);
          rsp_byte = byte_for(spi_cmd);
          pend = 3;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vld) vld_mon++;
    end
  end

  task automatic wait_vld(input string tag);
    int c = 0;
    logic [15:0] rt_e, az_c;
    int acc, fus;
    while (c < 200) begin
      @(posedge clk);
      #1;
      c++;
      if (vld) break;
    end
    check({tag, "_vld"}, 32'(vld), 32'd1);
    if (!vld) return;
    vld_cyc = cyc;
    rt_e = {rh_v, rl_v} - 16'h0050;
    check({tag, "_rt"}, 32'(ptch_rt), 32'(rt_e));
    az_c = {ah_v, al_v} - 16'h00A0;
    acc  = (int'($signed(az_c)) * 327) >>> 13;
    fus  = (acc > int'($signed(m_int[26:11]))) ? 1024 : -1024;
    m_int = m_int - 27'($signed(rt_e)) + 27'(fus);
    @(posedge clk);
    #1;
    check({tag, "_vld_1clk"}, 32'(vld), 32'd0);
    check({tag, "_int"}, 32'(dut.ptch_int_q), 32'(m_int));
    check({tag, "_ptch"}, 32'(ptch), 32'(m_int[26:11]));
    $display("[%0d] %s vld: ptch_rt=0x%04h ptch=0x%04h", cyc, tag, ptch_rt, ptch);
  endtask

  task automatic do_read(input string tag);
    INT = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    INT = 1'b0;
    wait_vld(tag);
  endtask

  task automatic run_init(input bit drop_int);
    int c = 0;
    int base;
    logic [15:0] exp_init[4];
    exp_init = '{16'h0D02, 16'h1160, 16'h1050, 16'h1460};
    base = cmd_log.size();
    while (c < 3000) begin
      @(posedge clk);
      #1;
      c++;
      if (spi_wrt) break;
    end
    check("init_first_cyc", 32'(c), 32'd1024);
    check("init_first_cmd", 32'(spi_cmd), 32'h0D02);
    c = 0;
    while (cmd_log.size() < base + 4 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (drop_int) INT = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("init_nwrt", 32'(cmd_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < cmd_log.size())
        check("init_cmd", 32'(cmd_log[base + i]), 32'(exp_init[i]));
  endtask

  initial begin
    int base, prev, mon0, c;
    logic [15:0] exp_rd[4];
    exp_rd = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    // Reset state, INT held high through init
    INT = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrt", 32'(spi_wrt), 32'd0);
    check("rst_cmd", 32'(spi_cmd), 32'h0000);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_rt", 32'(ptch_rt), 32'h0000);
    check("rst_ptch", 32'(ptch), 32'h0000);
    check("rst_timer", 32'(dut.timer_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init(1'b1);

    // Zero-offset sample: rate 0, accel 0 -> fusion -1024
    rl_v = 8'h50; rh_v = 8'h00; al_v = 8'hA0; ah_v = 8'h00;
    base = cmd_log.size();
    do_read("rd0");
    check("rd0_ncmd", 32'(cmd_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < cmd_log.size())
        check("rd0_cmd", 32'(cmd_log[base + i]), 32'(exp_rd[i]));
    check("rd0_int_lit", 32'(dut.ptch_int_q), 32'h7FF_FC00);
    check("rd0_ptch_lit", 32'(ptch), 32'hFFFF);

    // Constant rate 0x0100
    rh_v = 8'h01;
    for (int i = 0; i < 3; i++) do_read("rd_rate");

    // Back-to-back reads with INT held high
    INT = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_vld("b2b");
      if (i > 0) check("b2b_gap", 32'(vld_cyc - prev), 32'd18);
      prev = vld_cyc;
      if (i == 2) INT = 1'b0;
    end
    mon0 = vld_mon;
    repeat (40) @(posedge clk);
    #1;
    check("b2b_stop", 32'(vld_mon), 32'(mon0));

    // Reset while in RD_AL
    INT = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    INT = 1'b0;
    c = 0;
    while (c < 100 && !(spi_wrt && spi_cmd == 16'hAC00)) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("abort_in_rdal", 32'(spi_cmd), 32'hAC00);
    mon0 = vld_mon;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_wrt", 32'(spi_wrt), 32'd0);
    check("abort_cmd", 32'(spi_cmd), 32'h0000);
    check("abort_vld", 32'(vld), 32'd0);
    check("abort_rt", 32'(ptch_rt), 32'h0000);
    check("abort_ptch", 32'(ptch), 32'h0000);
    check("abort_int", 32'(dut.ptch_int_q), 32'd0);
    check("abort_timer", 32'(dut.timer_q), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_int = 27'd0;
    run_init(1'b0);
    check("abort_no_vld", 32'(vld_mon), 32'(mon0));

    // az_comp = 0x1000 -> ptch_acc = 163, ptch climbs and then dithers at the target
    rl_v = 8'h50; rh_v = 8'h00; al_v = 8'hA0; ah_v = 8'h10;
    INT = 1'b1;
    for (int i = 0; i < 340; i++) begin
      wait_vld("fuse");
      if (i == 338) INT = 1'b0;
    end
    check("fuse_settle", 32'(ptch == 16'd162 || ptch == 16'd163), 32'd1);
    check("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
